// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, default reset PC and the
// fetch-unit state encoding.
package mips_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel. master = fetch unit,
// slave = instruction memory.
interface ifu_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/ifu_npc.sv
// Next-PC selection: jr > jal/j > taken beq > sequential.
module ifu_npc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] ra,
  input  logic        nPC_sel,
  input  logic        zero,
  input  logic        if_jal,
  input  logic        if_jr,
  output logic [31:0] npc
);

  logic [31:0] ra_aligned;
  logic [31:0] jmp_tgt;
  logic [31:0] br_off;
  logic        is_j;

  // jr target low bits are dropped rather than faulted
  assign ra_aligned = ra & 32'hFFFF_FFFC;
  assign jmp_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign br_off     = {{14{instr[15]}}, instr[15:0], 2'b00};
  // plain j is recognised locally; decode only flags jal
  assign is_j       = (instr[31:26] == OP_J);

  // priority mux, arithmetic wraps modulo 2^32
  always_comb begin
    npc = pc_plus4;
    if (if_jr)                npc = ra_aligned;
    else if (if_jal || is_j)  npc = jmp_tgt;
    else if (nPC_sel && zero) npc = pc_plus4 + br_off;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry
// instruction buffer toward decode, next PC computed on consumption.
module ifu_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  ifu_fetch_if.master  imem,
  output logic [31:0]  instr,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  input  logic         nPC_sel,
  input  logic         zero,
  input  logic         if_jal,
  input  logic         if_jr,
  input  logic [31:0]  ra
);

  fetch_state_e state, state_nxt;
  logic         pc_ld, instr_ld;
  logic [31:0]  npc;

  ifu_npc u_npc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .ra       (ra),
    .nPC_sel  (nPC_sel),
    .zero     (zero),
    .if_jal   (if_jal),
    .if_jr    (if_jr),
    .npc      (npc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  // next state and load strobes; handshake inputs only matter in their own state
  always_comb begin
    state_nxt = state;
    pc_ld     = 1'b0;
    instr_ld  = 1'b0;
    case (state)
      S_REQ:  if (imem.req_ready) state_nxt = S_WAIT;
      S_WAIT: if (imem.rsp_valid) begin
                state_nxt = S_HOLD;
                instr_ld  = 1'b1;
              end
      S_HOLD: if (instr_ready) begin
                state_nxt = S_REQ;
                pc_ld     = 1'b1;
              end
      default: state_nxt = S_REQ;
    endcase
  end

  // PC advances only on the consuming edge; redirect inputs are sampled there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= {RESET_PC[31:2], 2'b00};
    else if (pc_ld) pc <= npc;
  end

  // instruction buffer, written only by the response in S_WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        instr <= 32'h0;
    else if (instr_ld) instr <= imem.rsp_data;
  end

  assign pc_plus4       = pc + 32'd4;
  assign imem.addr      = pc;
  // request is held off while reset is asserted
  assign imem.req_valid = rst_n && (state == S_REQ);
  assign instr_valid    = (state == S_HOLD);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: scripted instruction memory and decode side, with
// expected fetch addresses and instruction words queued as a scoreboard.
module tb_ifu_fetch;
  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        nPC_sel, zero, if_jal, if_jr;
  logic [31:0] ra;

  ifu_fetch_if bus ();

  ifu_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .nPC_sel     (nPC_sel),
    .zero        (zero),
    .if_jal      (if_jal),
    .if_jr       (if_jr),
    .ra          (ra)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] last_instr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_dec();
    instr_ready = 0; nPC_sel = 0; zero = 0; if_jal = 0; if_jr = 0; ra = 32'h0;
  endtask

  // wait (bounded) for a request and compare its address with the scoreboard
  task automatic check_next_req(output bit ok, output logic [31:0] a);
    logic [31:0] exp;
    ok = 0; a = 32'hx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_valid === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_timeout: no imem request within 50 cycles");
      return;
    end
    if (addr_q.size() == 0) begin
      errors++; ok = 0;
      $display("FAIL req_unexpected: addr=%h with empty scoreboard", bus.addr);
      return;
    end
    exp = addr_q.pop_front();
    a = exp;
    if (bus.addr !== exp || pc !== exp) begin
      errors++;
      $display("FAIL req_addr: addr=%h pc=%h expected %h", bus.addr, pc, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] data, input int rdy_lat, input int rsp_lat,
                          input int hold_lat, input bit spur,
                          input logic beq, input logic z, input logic jal, input logic jr,
                          input logic [31:0] ra_v, input logic [31:0] exp_p4,
                          input logic [31:0] exp_next);
    bit ok;
    logic [31:0] a0, e;
    int c0;
    check_next_req(ok, a0);
    if (!ok) return;
    c0 = cyc;
    // request stalled; optional spurious response in S_REQ
    for (int i = 0; i < rdy_lat; i++) begin
      bus.req_ready = 0;
      bus.rsp_valid = spur && (i == 1);
      bus.rsp_data  = 32'hBAD0_0000;
      @(negedge clk);
      checks++;
      if (bus.req_valid !== 1'b1 || bus.addr !== a0 || instr !== last_instr) begin
        errors++;
        $display("FAIL req_hold: valid=%b addr=%h instr=%h expected 1 %h %h",
                 bus.req_valid, bus.addr, instr, a0, last_instr);
      end
    end
    bus.rsp_valid = 0;
    bus.req_ready = 1;
    @(negedge clk);
    bus.req_ready = 0;
    checks++;
    if (bus.req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== last_instr) begin
      errors++;
      $display("FAIL wait_entry: req_valid=%b instr_valid=%b instr=%h expected 0 0 %h",
               bus.req_valid, instr_valid, instr, last_instr);
    end
    // response delayed; stray ready/consume strobes must be ignored
    for (int i = 0; i < rsp_lat; i++) begin
      bus.req_ready = spur;
      instr_ready   = spur;
      @(negedge clk);
      checks++;
      if (bus.req_valid !== 1'b0 || instr_valid !== 1'b0 || pc !== a0) begin
        errors++;
        $display("FAIL wait_hold: req_valid=%b instr_valid=%b pc=%h expected 0 0 %h",
                 bus.req_valid, instr_valid, pc, a0);
      end
    end
    bus.req_ready = 0;
    instr_ready   = 0;
    bus.rsp_valid = 1;
    bus.rsp_data  = data;
    instr_q.push_back(data);
    @(negedge clk);
    bus.rsp_valid = 0;
    e = instr_q.pop_front();
    last_instr = e;
    checks++;
    if (instr_valid !== 1'b1 || instr !== e || pc !== a0 || pc_plus4 !== exp_p4) begin
      errors++;
      $display("FAIL hold_data: valid=%b instr=%h pc=%h p4=%h expected 1 %h %h %h",
               instr_valid, instr, pc, pc_plus4, e, a0, exp_p4);
    end
    // decode stalls; junk redirect and responses must not disturb anything
    for (int i = 0; i < hold_lat; i++) begin
      instr_ready = 0; if_jr = 1; if_jal = 1; ra = 32'hDEAD_BEEF;
      bus.rsp_valid = 1; bus.rsp_data = ~data;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== e || pc !== a0 || bus.req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall: valid=%b instr=%h pc=%h req=%b expected 1 %h %h 0",
                 instr_valid, instr, pc, bus.req_valid, e, a0);
      end
    end
    bus.rsp_valid = 0;
    instr_ready = 1; nPC_sel = beq; zero = z; if_jal = jal; if_jr = jr; ra = ra_v;
    addr_q.push_back(exp_next);
    @(negedge clk);
    clear_dec();
    checks++;
    if (instr_valid !== 1'b0 || bus.req_valid !== 1'b1) begin
      errors++;
      $display("FAIL consume: instr_valid=%b req_valid=%b expected 0 1", instr_valid, bus.req_valid);
    end
    if (rdy_lat == 0 && rsp_lat == 0 && hold_lat == 0) begin
      checks++;
      if (cyc - c0 !== 3) begin
        errors++;
        $display("FAIL throughput: %0d cycles between requests expected 3", cyc - c0);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_dec();
    bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_data = 32'h0;
    last_instr = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_valid !== 1'b0 || bus.addr !== 32'h3000 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || pc !== 32'h3000 || pc_plus4 !== 32'h3004) begin
      errors++;
      $display("FAIL reset_vals: req=%b addr=%h iv=%b instr=%h pc=%h p4=%h expected 0 3000 0 0 3000 3004",
               bus.req_valid, bus.addr, instr_valid, instr, pc, pc_plus4);
    end
    rst_n = 1;
    addr_q.push_back(32'h0000_3000);
  endtask

  task automatic test_throughput();
    do_fetch(32'h3402_0005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h3004);
  endtask

  task automatic test_jump_branch();
    do_fetch(32'h0800_0C04, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 32'h3010); // j
    do_fetch(32'h1022_FFFC, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h3014, 32'h3004); // beq taken
    do_fetch(32'h0800_0C04, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 32'h3010);
    do_fetch(32'h1022_FFFC, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h3014, 32'h3014); // beq not taken
    do_fetch(32'h0800_0C08, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3018, 32'h3020);
  endtask

  task automatic test_jal_jr();
    do_fetch(32'h0C00_0C10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h3024, 32'h3040);
    do_fetch(32'h03E0_0008, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_3047, 32'h3044, 32'h3044);
  endtask

  task automatic test_stall();
    do_fetch(32'h2008_0001, 4, 5, 3, 1, 0, 0, 0, 0, 0, 32'h3048, 32'h3048);
  endtask

  task automatic test_wrap();
    do_fetch(32'h03E0_0008, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h304C, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000);
    do_fetch(32'h1022_FFFC, 0, 1, 0, 0, 1, 1, 0, 0, 0, 32'h0000_0004, 32'hFFFF_FFF4);
    do_fetch(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0000_304B, 32'hFFFF_FFF8, 32'h3048);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] a0;
    check_next_req(ok, a0);
    bus.req_ready = 1;
    @(negedge clk);
    bus.req_ready = 0;
    #1 rst_n = 0;
    #1;
    checks++;
    if (bus.req_valid !== 1'b0 || bus.addr !== 32'h3000 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || pc_plus4 !== 32'h3004) begin
      errors++;
      $display("FAIL reset_mid: req=%b addr=%h iv=%b instr=%h p4=%h expected 0 3000 0 0 3004",
               bus.req_valid, bus.addr, instr_valid, instr, pc_plus4);
    end
    @(negedge clk);
    rst_n = 1;
    last_instr = 32'h0;
    addr_q.push_back(32'h0000_3000);
    do_fetch(32'h3402_0005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h3004);
    check_next_req(ok, a0);
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_jump_branch();
    test_jal_jr();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
